// File: rtl/poly_reg_bank_if.sv
// Control and data bundle for the AMNS operand/result register bank.
// The bench drives the master side; the bank sits on the slave side.
interface poly_reg_bank_if #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5,
  parameter int S          = 4
);
  logic [1:0]              INPUT_reg_sel_i;
  logic                    INPUT_reg_en_i;
  logic                    load_RES_reg_en_i;
  logic                    store_RES_reg_en_i;
  logic [S-1:0]            A_reg_coeff_rot_i;
  logic                    B_reg_shift_i;
  logic                    M_reg_shift_i;
  logic                    M_prime_0_rot_i;
  logic [WORD_WIDTH-1:0]   INPUT_reg_din_i;
  logic [N*WORD_WIDTH-1:0] RES_reg_din_i;
  logic [S*WORD_WIDTH-1:0] A_reg_dout_o;
  logic [N*WORD_WIDTH-1:0] B_reg_dout_o;
  logic [WORD_WIDTH-1:0]   M_reg_dout_o;
  logic [WORD_WIDTH-1:0]   M_prime_0_reg_dout_o;
  logic [WORD_WIDTH-1:0]   RES_reg_dout_o;

  modport master (
    output INPUT_reg_sel_i, INPUT_reg_en_i,
    output load_RES_reg_en_i, store_RES_reg_en_i,
    output A_reg_coeff_rot_i, B_reg_shift_i,
    output M_reg_shift_i, M_prime_0_rot_i,
    output INPUT_reg_din_i, RES_reg_din_i,
    input  A_reg_dout_o, B_reg_dout_o,
    input  M_reg_dout_o, M_prime_0_reg_dout_o,
    input  RES_reg_dout_o
  );

  modport slave (
    input  INPUT_reg_sel_i, INPUT_reg_en_i,
    input  load_RES_reg_en_i, store_RES_reg_en_i,
    input  A_reg_coeff_rot_i, B_reg_shift_i,
    input  M_reg_shift_i, M_prime_0_rot_i,
    input  INPUT_reg_din_i, RES_reg_din_i,
    output A_reg_dout_o, B_reg_dout_o,
    output M_reg_dout_o, M_prime_0_reg_dout_o,
    output RES_reg_dout_o
  );
endinterface

// File: rtl/poly_reg_bank.sv
// Operand (A, B, M, M'0) and result (RES) word registers for the AMNS multiplier.
// Define POLY_REG_BANK_STORE_ROT_EN to make the RES drain rotate instead of zero-fill.
module poly_reg_bank #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5,
  parameter int S          = 4
) (
  input logic clock_i,
  input logic reset_i,
  poly_reg_bank_if.slave bus
);

  localparam int W  = WORD_WIDTH;
  localparam int RW = N * S * W;
  localparam int NW = N * W;
  localparam int SW = S * W;

  logic [RW-1:0] r_a;
  logic [RW-1:0] r_b;
  logic [RW-1:0] r_m;
  logic [RW-1:0] r_res;
  logic [NW-1:0] r_mp;

  logic [RW-1:0] w_a_nxt;
  logic [RW-1:0] w_b_nxt;
  logic [RW-1:0] w_m_nxt;
  logic [RW-1:0] w_res_nxt;
  logic [NW-1:0] w_mp_nxt;

  logic w_ld_a;
  logic w_ld_b;
  logic w_ld_m;
  logic w_ld_mp;

  always_comb begin
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    w_ld_m  = 1'b0;
    w_ld_mp = 1'b0;
    unique case (bus.INPUT_reg_sel_i)
      2'b00: w_ld_a  = bus.INPUT_reg_en_i;
      2'b01: w_ld_b  = bus.INPUT_reg_en_i;
      2'b10: w_ld_m  = bus.INPUT_reg_en_i;
      2'b11: w_ld_mp = bus.INPUT_reg_en_i;
      default: ;
    endcase
  end

  // Each A section is an independent N-word ring.
  always_comb begin
    w_a_nxt = r_a;
    if (w_ld_a) begin
      w_a_nxt = {bus.INPUT_reg_din_i, r_a[RW-1:W]};
    end else begin
      for (int j = 0; j < S; j++) begin
        if (bus.A_reg_coeff_rot_i[j]) begin
          w_a_nxt[j*NW +: NW] =
            {r_a[j*NW +: W], r_a[j*NW+W +: NW-W]};
        end
      end
    end
  end

  always_comb begin
    w_b_nxt = r_b;
    if (w_ld_b) begin
      w_b_nxt = {bus.INPUT_reg_din_i, r_b[RW-1:W]};
    end else if (bus.B_reg_shift_i) begin
      w_b_nxt = {{W{1'b0}}, r_b[RW-1:W]};
    end
  end

  always_comb begin
    w_m_nxt = r_m;
    if (w_ld_m) begin
      w_m_nxt = {bus.INPUT_reg_din_i, r_m[RW-1:W]};
    end else if (bus.M_reg_shift_i) begin
      w_m_nxt = {{W{1'b0}}, r_m[RW-1:W]};
    end
  end

  always_comb begin
    w_mp_nxt = r_mp;
    if (w_ld_mp) begin
      w_mp_nxt = {bus.INPUT_reg_din_i, r_mp[NW-1:W]};
    end else if (bus.M_prime_0_rot_i) begin
      w_mp_nxt = {r_mp[W-1:0], r_mp[NW-1:W]};
    end
  end

  // Capture pushes one word per coefficient; drain walks the whole register.
  always_comb begin
    w_res_nxt = r_res;
    if (bus.load_RES_reg_en_i) begin
      for (int i = 0; i < N; i++) begin
        w_res_nxt[i*SW +: SW] =
          {bus.RES_reg_din_i[i*W +: W], r_res[i*SW+W +: SW-W]};
      end
    end else if (bus.store_RES_reg_en_i) begin
`ifdef POLY_REG_BANK_STORE_ROT_EN
      w_res_nxt = {r_res[W-1:0], r_res[RW-1:W]};
`else
      w_res_nxt = {{W{1'b0}}, r_res[RW-1:W]};
`endif
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_a   <= '0;
      r_b   <= '0;
      r_m   <= '0;
      r_mp  <= '0;
      r_res <= '0;
    end else begin
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_m   <= w_m_nxt;
      r_mp  <= w_mp_nxt;
      r_res <= w_res_nxt;
    end
  end

  for (genvar j = 0; j < S; j++) begin : g_a_tap
    assign bus.A_reg_dout_o[j*W +: W] = r_a[j*NW +: W];
  end

  for (genvar l = 0; l < N; l++) begin : g_b_tap
    assign bus.B_reg_dout_o[l*W +: W] = r_b[l*SW +: W];
  end

  assign bus.M_reg_dout_o         = r_m[W-1:0];
  assign bus.M_prime_0_reg_dout_o = r_mp[W-1:0];
  assign bus.RES_reg_dout_o       = r_res[W-1:0];

endmodule

// File: tb/tb_poly_reg_bank.sv
// Self-checking bench for poly_reg_bank: expectations are queued as
// stimulus is driven and compared one time unit after the clock edge.
module tb_poly_reg_bank;
  localparam int W  = 17;
  localparam int N  = 5;
  localparam int S  = 4;
  localparam int NS = N * S;

  logic clock_i = 1'b0;
  logic reset_i;
  always #5 clock_i = ~clock_i;

  poly_reg_bank_if #(.WORD_WIDTH(W), .N(N), .S(S)) bus ();

  poly_reg_bank #(.WORD_WIDTH(W), .N(N), .S(S)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    int          id;
    logic [84:0] exp;
    string       tag;
  } sb_t;

  typedef struct {
    logic [S-1:0]   rot;
    logic           mrot;
    logic [S*W-1:0] ea;
    logic [W-1:0]   emp;
  } rv_t;

  sb_t   q[$];
  rv_t   tbl[25];
  int    checks = 0;
  int    errors = 0;
  string onames[5] = '{"A_dout", "B_dout", "M_dout", "MP_dout", "RES_dout"};

  logic [W-1:0] a[NS], b[NS], m[NS], r[NS], r2[NS], a2[N];
  logic [W-1:0] mp[N];

  function automatic logic [84:0] act(int id);
    case (id)
      0: return 85'(bus.A_reg_dout_o);
      1: return 85'(bus.B_reg_dout_o);
      2: return 85'(bus.M_reg_dout_o);
      3: return 85'(bus.M_prime_0_reg_dout_o);
      default: return 85'(bus.RES_reg_dout_o);
    endcase
  endfunction

  task automatic expect_out(int id, logic [84:0] e, string tag);
    sb_t s;
    s.id  = id;
    s.exp = e;
    s.tag = tag;
    q.push_back(s);
  endtask

  task automatic expect_all_zero(string tag);
    for (int i = 0; i < 5; i++) expect_out(i, '0, tag);
  endtask

  task automatic drain_sb();
    sb_t s;
    logic [84:0] got;
    while (q.size() > 0) begin
      s   = q.pop_front();
      got = act(s.id);
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s %s: got %h want %h",
                 s.tag, onames[s.id], got, s.exp);
      end
    end
  endtask

  task automatic clr();
    bus.INPUT_reg_sel_i    = '0;
    bus.INPUT_reg_en_i     = 1'b0;
    bus.load_RES_reg_en_i  = 1'b0;
    bus.store_RES_reg_en_i = 1'b0;
    bus.A_reg_coeff_rot_i  = '0;
    bus.B_reg_shift_i      = 1'b0;
    bus.M_reg_shift_i      = 1'b0;
    bus.M_prime_0_rot_i    = 1'b0;
    bus.INPUT_reg_din_i    = '0;
    bus.RES_reg_din_i      = '0;
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
    drain_sb();
    @(negedge clock_i);
    clr();
  endtask

  function automatic logic [S*W-1:0] a_taps(int rots);
    logic [S*W-1:0] e;
    for (int s = 0; s < S; s++) e[s*W +: W] = a[N*s + (rots % N)];
    return e;
  endfunction

  initial begin
    logic [S*W-1:0] ea;
    logic [N*W-1:0] eb;
    logic [N*W-1:0] rd;

    for (int k = 0; k < NS; k++) begin
      a[k]  = W'($urandom);
      b[k]  = W'($urandom);
      m[k]  = W'($urandom);
      r[k]  = W'($urandom);
      r2[k] = W'($urandom);
    end
    for (int k = 0; k < N; k++) begin
      mp[k] = W'($urandom);
      a2[k] = W'($urandom);
    end

    for (int j = 0; j < S; j++) begin
      for (int i = 1; i <= N; i++) begin
        tbl[j*N+i-1].rot    = '0;
        tbl[j*N+i-1].rot[j] = 1'b1;
        tbl[j*N+i-1].mrot   = 1'b0;
        for (int s = 0; s < S; s++)
          tbl[j*N+i-1].ea[s*W +: W] = (s == j) ? a[N*s + (i % N)] : a[N*s];
        tbl[j*N+i-1].emp = mp[0];
      end
    end
    for (int i = 1; i <= N; i++) begin
      tbl[20+i-1].rot  = '1;
      tbl[20+i-1].mrot = 1'b1;
      tbl[20+i-1].ea   = a_taps(i);
      tbl[20+i-1].emp  = mp[i % N];
    end

    clr();
    reset_i = 1'b1;
    #1 reset_i = 1'b0;
    #1;
    expect_all_zero("reset");
    drain_sb();
    @(negedge clock_i);
    reset_i = 1'b1;

    for (int k = 0; k < NS; k++) begin
      bus.INPUT_reg_en_i  = 1'b1;
      bus.INPUT_reg_sel_i = 2'b00;
      bus.INPUT_reg_din_i = a[k];
      if (k == 4) expect_out(0, 85'({a[0], {(3*W){1'b0}}}), "loadA_5w");
      if (k == NS - 1) begin
        expect_out(0, 85'(a_taps(0)), "loadA");
        expect_out(1, '0, "loadA_B_untouched");
      end
      step();
    end

    for (int k = 0; k < NS; k++) begin
      bus.INPUT_reg_en_i  = 1'b1;
      bus.INPUT_reg_sel_i = 2'b01;
      bus.INPUT_reg_din_i = b[k];
      if (k == NS - 1) begin
        for (int l = 0; l < N; l++) eb[l*W +: W] = b[S*l];
        expect_out(1, 85'(eb), "loadB");
        expect_out(0, 85'(a_taps(0)), "loadB_A_untouched");
      end
      step();
    end

    for (int k = 0; k < NS; k++) begin
      bus.INPUT_reg_en_i  = 1'b1;
      bus.INPUT_reg_sel_i = 2'b10;
      bus.INPUT_reg_din_i = m[k];
      if (k == NS - 1) begin
        expect_out(2, 85'(m[0]), "loadM");
        expect_out(3, '0, "loadM_MP_untouched");
      end
      step();
    end

    for (int k = 0; k < N; k++) begin
      bus.INPUT_reg_en_i  = 1'b1;
      bus.INPUT_reg_sel_i = 2'b11;
      bus.INPUT_reg_din_i = mp[k];
      if (k == N - 1) begin
        expect_out(3, 85'(mp[0]), "loadMP");
        expect_out(2, 85'(m[0]), "loadMP_M_untouched");
      end
      step();
    end

    for (int t = 0; t < 25; t++) begin
      bus.A_reg_coeff_rot_i = tbl[t].rot;
      bus.M_prime_0_rot_i   = tbl[t].mrot;
      expect_out(0, 85'(tbl[t].ea), $sformatf("rot%0d", t));
      expect_out(3, 85'(tbl[t].emp), $sformatf("rot%0d", t));
      step();
    end

    for (int k = 1; k <= NS; k++) begin
      bus.B_reg_shift_i = 1'b1;
      bus.M_reg_shift_i = 1'b1;
      for (int l = 0; l < N; l++)
        eb[l*W +: W] = (S*l + k < NS) ? b[S*l + k] : '0;
      expect_out(1, 85'(eb), $sformatf("shiftB%0d", k));
      expect_out(2, 85'((k < NS) ? m[k] : '0), $sformatf("shiftM%0d", k));
      step();
    end

    // Capture with drain also requested: capture must win.
    for (int j = 0; j < S; j++) begin
      for (int i = 0; i < N; i++) rd[i*W +: W] = r[S*i + j];
      bus.RES_reg_din_i      = rd;
      bus.load_RES_reg_en_i  = 1'b1;
      bus.store_RES_reg_en_i = 1'b1;
      expect_out(4, 85'((j == S - 1) ? r[0] : '0), $sformatf("capRES%0d", j));
      step();
    end

    for (int c = 1; c <= NS; c++) begin
      bus.store_RES_reg_en_i = 1'b1;
`ifdef POLY_REG_BANK_STORE_ROT_EN
      expect_out(4, 85'(r[c % NS]), $sformatf("drain%0d", c));
`else
      expect_out(4, 85'((c < NS) ? r[c] : '0), $sformatf("drain%0d", c));
`endif
      step();
    end

    for (int j = 0; j < S; j++) begin
      for (int i = 0; i < N; i++) rd[i*W +: W] = r2[S*i + j];
      bus.RES_reg_din_i     = rd;
      bus.load_RES_reg_en_i = 1'b1;
      step();
    end
    for (int c = 1; c <= 7; c++) begin
      bus.store_RES_reg_en_i = 1'b1;
      expect_out(4, 85'(r2[c]), $sformatf("drain2_%0d", c));
      step();
    end

    bus.store_RES_reg_en_i = 1'b1;
    #2 reset_i = 1'b0;
    #1;
    expect_all_zero("midreset");
    drain_sb();
    @(negedge clock_i);
    reset_i = 1'b1;
    clr();
    expect_all_zero("postreset");
    step();

    for (int k = 0; k < N; k++) begin
      bus.INPUT_reg_en_i  = 1'b1;
      bus.INPUT_reg_sel_i = 2'b00;
      bus.INPUT_reg_din_i = a2[k];
      if (k == N - 1) begin
        ea = '0;
        ea[3*W +: W] = a2[0];
        expect_out(0, 85'(ea), "reloadA");
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
